uart_imem_loader: RTL and testbench
===================================

// Module: uart_imem_loader
// PURPOSE
//  Serial program loader upstream of the instruction memory. Receives a program over
//  UART (8N1) and assembles big-endian 32-bit words. Drives word-addressed write
//  strobes into the instruction-memory load port while the CPU is halted
//  (run_switch low). Ends loading after MAX_WORDS words and raises load_done.
// PARAMETERS
//  CLKS_PER_BIT  434  clock cycles per UART bit (50 MHz / 115200); must be >= 4
//  MAX_WORDS     43   words accepted before load_done; matches imem MEMORY_SIZE
// PORTS
//  clock          in   1   system clock; all state changes on posedge
//  reset          in   1   synchronous, active-high; clears all state
//  rx             in   1   asynchronous UART serial input, idle high
//  enable         in   1   1 = loading allowed (tie to ~run_switch)
//  imem_address   out  32  word index for imem input_address (not byte address)
//  imem_data      out  32  assembled instruction word for imem input_data
//  imem_write     out  1   one-cycle write strobe for imem write_enabled
//  word_count     out  32  number of words written since reset
//  load_done      out  1   high once word_count == MAX_WORDS; sticky until reset
//  err_framing    out  1   sticky: a stop bit sampled low since reset
// BEHAVIOUR
//  - Reset: all outputs 0, RX FSM IDLE, byte lane 0, synchronizer flops preset to 1.
//  - rx passes through a 2-flop synchronizer before any use; all timing below is
//    measured from the synchronized signal.
//  - RX FSM IDLE->START on a synchronized falling edge.
//  - START: wait CLKS_PER_BIT/2 cycles. If rx is still 0, go to DATA. Otherwise
//    treat it as a glitch and return to IDLE.
//  - DATA: sample 8 bits, LSB first, every CLKS_PER_BIT cycles, at mid-bit.
//  - STOP: after CLKS_PER_BIT more cycles, sample rx.
//    - rx = 1: byte valid for 1 cycle, then IDLE.
//    - rx = 0: set err_framing, discard the byte, and clear the partial word
//      (lane = 0). Stay in IDLE until rx is seen high, so no false start.
//  - Word assembly: lane 0 goes to [31:24], lane 1 to [23:16], lane 2 to [15:8],
//    lane 3 to [7:0]. Lane increments mod 4 on each valid byte.
//  - Write timing: on the valid 4th byte, imem_data and imem_address
//    (= word_count) update and imem_write pulses high the next cycle, for exactly
//    one cycle. word_count increments in the same cycle as the pulse.
//  - imem_data and imem_address hold their values after the pulse (imem is
//    registered). Latency: last stop-bit sample to imem_write = 2 cycles.
//  - load_done goes high in the cycle after the strobe that makes
//    word_count == MAX_WORDS. Once load_done is high, further bytes are received
//    but ignored: no strobe, and word_count stays saturated.
//  - enable low: FSM forced to IDLE, in-flight frame and partial word discarded,
//    imem_write held 0. word_count, load_done and err_framing are kept.
//    Re-asserting enable resumes at the next start bit. The next write goes to
//    imem_address = word_count.
//  - Reset mid-frame or mid-word: everything cleared, with no strobe in the
//    reset cycle. Reset has priority over enable and byte_valid.
//  - Strobe and enable falling in the same cycle: the strobe is cancelled and
//    word_count is not incremented.
//  - Arithmetic: bit timer is $clog2(CLKS_PER_BIT) bits, bit index 3 bits,
//    lane 2 bits; word_count saturates at MAX_WORDS and never wraps.
// STRUCTURE
//  - uart_defs.vh: RX state encodings (IDLE/START/DATA/STOP), the default
//    CLKS_PER_BIT, and the big-endian lane-to-bit-range map. Shared with a future
//    UART TX/debug block.
//  - Sub-module uart_rx_8n1 (clock, reset, enable, rx -> byte[7:0], byte_valid,
//    frame_err) contains the synchronizer, timers and FSM.
//  - The top level holds the lane counter, word shift register, address/count
//    logic and the done/error flags.
// TESTING (bench uses CLKS_PER_BIT=4, MAX_WORDS=3)
//  1. Reset, enable=1, send 0x20 0x08 0x00 0x05 -> one imem_write pulse with
//     address 0, data 0x20080005, word_count=1.
//  2. Send 12 bytes forming 0x11111111, 0x22222222, 0x33333333, then 4 more ->
//     3 strobes at addr 0,1,2. load_done=1 after the 3rd. No 4th strobe;
//     word_count stays 3.
//  3. Send 2 bytes, then a frame with stop bit 0, then 0xAA 0xBB 0xCC 0xDD ->
//     err_framing=1 and one strobe, data 0xAABBCCDD, addr 0.
//  4. 1-cycle low glitch on rx while idle -> no byte, no strobe, FSM returns to
//     IDLE.
//  5. Send 3 bytes, drop enable for 10 cycles, raise it, send 0x01 0x02 0x03 0x04
//     -> single strobe with data 0x01020304, addr 0.
//  6. Assert reset mid-DATA of byte 4 -> no strobe; all outputs 0 the cycle
//     after reset.

Source files
------------

// File: rtl/uart_imem_loader_pkg.sv
// uart_imem_loader_pkg: RX state encodings, default timing and the big-endian lane map
package uart_imem_loader_pkg;
  typedef enum logic [1:0] {RX_IDLE, RX_START, RX_DATA, RX_STOP} rx_state_e;
  localparam int DEFAULT_CLKS_PER_BIT = 434;
  localparam int DEFAULT_MAX_WORDS = 43;
  // lane 0 lands in [31:24], lane 3 in [7:0]
  function automatic logic [31:0] put_lane(logic [31:0] w, logic [1:0] lane, logic [7:0] b);
    logic [31:0] r;
    r = w;
    r[{~lane, 3'b000} +: 8] = b;
    return r;
  endfunction
endpackage

// File: rtl/uart_imem_loader_if.sv
// uart_imem_loader_if: instruction-memory load port
interface uart_imem_loader_if;
  logic [31:0] address;
  logic [31:0] data;
  logic        write;
  modport master (output address, data, write);
  modport slave (input address, data, write);
endinterface

// File: rtl/uart_imem_loader_rx.sv
// uart_rx_8n1: synchronized 8N1 receiver producing one-cycle byte_valid / frame_err pulses
module uart_rx_8n1 import uart_imem_loader_pkg::*; #(
  parameter int CLKS_PER_BIT = DEFAULT_CLKS_PER_BIT
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       enable,
  input  logic       rx,
  output logic [7:0] rx_byte,
  output logic       byte_valid,
  output logic       frame_err
);
  localparam int TW = $clog2(CLKS_PER_BIT);
  localparam logic [TW-1:0] FULL = TW'(CLKS_PER_BIT - 1);
  localparam logic [TW-1:0] HALF = TW'(CLKS_PER_BIT / 2 - 1);
  rx_state_e state_q, state_d;
  logic [1:0] sync_q, sync_d;
  logic prev_q, prev_d, valid_q, valid_d, err_q, err_d, rx_s, tick;
  logic [TW-1:0] tmr_q, tmr_d;
  logic [2:0] bit_q, bit_d;
  logic [7:0] shift_q, shift_d;
  assign rx_s = sync_q[1];
  assign tick = tmr_q == FULL;
  always_comb begin
    sync_d = {sync_q[0], rx};
    prev_d = rx_s;
    state_d = state_q;
    tmr_d = tmr_q + 1'b1;
    bit_d = bit_q;
    shift_d = shift_q;
    valid_d = 1'b0;
    err_d = 1'b0;
    case (state_q)
      RX_IDLE: begin
        tmr_d = '0;
        state_d = (prev_q & ~rx_s) ? RX_START : RX_IDLE;
      end
      RX_START: if (tmr_q == HALF) begin
        tmr_d = '0;
        bit_d = 3'd0;
        state_d = rx_s ? RX_IDLE : RX_DATA;
      end
      RX_DATA: if (tick) begin
        tmr_d = '0;
        shift_d = {rx_s, shift_q[7:1]};
        bit_d = bit_q + 3'd1;
        state_d = (bit_q == 3'd7) ? RX_STOP : RX_DATA;
      end
      RX_STOP: if (tick) begin
        tmr_d = '0;
        valid_d = rx_s;
        err_d = ~rx_s;
        state_d = RX_IDLE;
      end
      default: state_d = RX_IDLE;
    endcase
    if (!enable) begin
      state_d = RX_IDLE;
      tmr_d = '0;
      valid_d = 1'b0;
      err_d = 1'b0;
    end
  end
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q <= RX_IDLE;
      sync_q <= 2'b11;
      prev_q <= 1'b1;
      tmr_q <= '0;
      bit_q <= '0;
      shift_q <= '0;
      valid_q <= 1'b0;
      err_q <= 1'b0;
    end else begin
      state_q <= state_d;
      sync_q <= sync_d;
      prev_q <= prev_d;
      tmr_q <= tmr_d;
      bit_q <= bit_d;
      shift_q <= shift_d;
      valid_q <= valid_d;
      err_q <= err_d;
    end
  end
  assign rx_byte = shift_q;
  assign byte_valid = valid_q;
  assign frame_err = err_q;
endmodule

// File: rtl/uart_imem_loader.sv
// uart_imem_loader: assembles UART bytes into big-endian words and strobes them into imem
module uart_imem_loader import uart_imem_loader_pkg::*; #(
  parameter int CLKS_PER_BIT = DEFAULT_CLKS_PER_BIT,
  parameter int MAX_WORDS = DEFAULT_MAX_WORDS
) (
  input  logic                clock,
  input  logic                reset,
  input  logic                rx,
  input  logic                enable,
  uart_imem_loader_if.master  imem,
  output logic [31:0]         word_count,
  output logic                load_done,
  output logic                err_framing
);
  localparam logic [31:0] MAX = 32'(MAX_WORDS);
  logic [7:0] rx_byte;
  logic rx_valid, rx_err, acc, strobe;
  logic [1:0] lane_q, lane_d;
  logic [31:0] word_q, word_d, data_q, data_d, addr_q, addr_d, count_q, count_d;
  logic wr_q, wr_d, done_q, done_d, err_q, err_d;
  uart_rx_8n1 #(.CLKS_PER_BIT(CLKS_PER_BIT)) u_rx (
    .clock(clock), .reset(reset), .enable(enable), .rx(rx),
    .rx_byte(rx_byte), .byte_valid(rx_valid), .frame_err(rx_err)
  );
  // the pending strobe is gated live so enable falling in its cycle cancels it
  assign strobe = wr_q & enable & ~reset;
  always_comb begin
    acc = rx_valid & enable & (count_q != MAX);
    lane_d = (!enable || rx_err) ? 2'd0 : acc ? lane_q + 2'd1 : lane_q;
    word_d = acc ? put_lane(word_q, lane_q, rx_byte) : word_q;
    wr_d = acc & (lane_q == 2'd3);
    data_d = wr_d ? word_d : data_q;
    addr_d = wr_d ? count_q : addr_q;
    count_d = count_q + 32'(strobe);
    done_d = done_q | (count_d == MAX);
    err_d = err_q | rx_err;
  end
  always_ff @(posedge clock) begin
    if (reset) begin
      lane_q <= '0;
      word_q <= '0;
      data_q <= '0;
      addr_q <= '0;
      count_q <= '0;
      wr_q <= 1'b0;
      done_q <= 1'b0;
      err_q <= 1'b0;
    end else begin
      lane_q <= lane_d;
      word_q <= word_d;
      data_q <= data_d;
      addr_q <= addr_d;
      count_q <= count_d;
      wr_q <= wr_d;
      done_q <= done_d;
      err_q <= err_d;
    end
  end
  assign imem.address = addr_q;
  assign imem.data = data_q;
  assign imem.write = strobe;
  assign word_count = count_q;
  assign load_done = done_q;
  assign err_framing = err_q;
endmodule

// File: tb/tb_uart_imem_loader.sv
// tb_uart_imem_loader: directed checks of the UART program loader at 4 clocks per bit
module tb_uart_imem_loader;
  import uart_imem_loader_pkg::*;
  logic clock = 1'b0, reset = 1'b1, rx = 1'b1, enable = 1'b1;
  logic [31:0] word_count;
  logic load_done, err_framing;
  int errors = 0, checks = 0, nwr = 0, base = 0;
  logic [31:0] wa [16], wd [16];
  uart_imem_loader_if imem ();
  uart_imem_loader #(.CLKS_PER_BIT(4), .MAX_WORDS(3)) dut (
    .clock(clock), .reset(reset), .rx(rx), .enable(enable), .imem(imem),
    .word_count(word_count), .load_done(load_done), .err_framing(err_framing)
  );
  always #5 clock = ~clock;
  always @(negedge clock) if (imem.write === 1'b1) begin
    if (nwr < 16) begin
      wa[nwr] = imem.address;
      wd[nwr] = imem.data;
    end
    nwr++;
  end
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, got, exp);
    end
  endtask
  task automatic bit_out(input logic v);
    @(posedge clock);
    #1 rx = v;
    repeat (3) @(posedge clock);
  endtask
  task automatic send_byte(input logic [7:0] b, input logic stop);
    bit_out(1'b0);
    for (int i = 0; i < 8; i++) bit_out(b[i]);
    bit_out(stop);
    bit_out(1'b1);
  endtask
  task automatic send_word(input logic [31:0] w);
    for (int i = 3; i >= 0; i--) send_byte(w[8*i +: 8], 1'b1);
  endtask
  task automatic do_reset();
    @(posedge clock);
    #1 reset = 1'b1;
    rx = 1'b1;
    repeat (2) @(posedge clock);
    #1 reset = 1'b0;
  endtask
  task automatic settle();
    repeat (6) @(posedge clock);
    @(negedge clock);
  endtask
  initial begin
    do_reset();
    @(negedge clock);
    chk("reset_write", 32'(imem.write), 32'd0);
    chk("reset_addr", imem.address, 32'd0);
    chk("reset_data", imem.data, 32'd0);
    chk("reset_count", word_count, 32'd0);
    chk("reset_done", 32'(load_done), 32'd0);
    chk("reset_err", 32'(err_framing), 32'd0);
    base = nwr;
    send_word(32'h20080005);
    settle();
    chk("t1_strobes", 32'(nwr - base), 32'd1);
    chk("t1_addr", wa[base], 32'd0);
    chk("t1_data", wd[base], 32'h20080005);
    chk("t1_count", word_count, 32'd1);
    chk("t1_hold_data", imem.data, 32'h20080005);
    do_reset();
    base = nwr;
    send_word(32'h11111111);
    send_word(32'h22222222);
    send_word(32'h33333333);
    settle();
    chk("t2_strobes", 32'(nwr - base), 32'd3);
    for (int i = 0; i < 3; i++) begin
      chk("t2_addr", wa[base + i], 32'(i));
      chk("t2_data", wd[base + i], {4{8'h11 * 8'(i + 1)}});
    end
    chk("t2_done", 32'(load_done), 32'd1);
    send_word(32'h44444444);
    settle();
    chk("t2_no_extra", 32'(nwr - base), 32'd3);
    chk("t2_count_sat", word_count, 32'd3);
    chk("t2_done_sticky", 32'(load_done), 32'd1);
    do_reset();
    base = nwr;
    send_byte(8'h12, 1'b1);
    send_byte(8'h34, 1'b1);
    send_byte(8'h56, 1'b0);
    settle();
    chk("t3_err", 32'(err_framing), 32'd1);
    send_word(32'hAABBCCDD);
    settle();
    chk("t3_strobes", 32'(nwr - base), 32'd1);
    chk("t3_addr", wa[base], 32'd0);
    chk("t3_data", wd[base], 32'hAABBCCDD);
    chk("t3_err_sticky", 32'(err_framing), 32'd1);
    base = nwr;
    @(posedge clock);
    #1 rx = 1'b0;
    @(posedge clock);
    #1 rx = 1'b1;
    repeat (12) @(posedge clock);
    @(negedge clock);
    chk("t4_no_strobe", 32'(nwr - base), 32'd0);
    chk("t4_state", 32'(dut.u_rx.state_q), 32'(RX_IDLE));
    chk("t4_count", word_count, 32'd1);
    do_reset();
    base = nwr;
    send_byte(8'hF1, 1'b1);
    send_byte(8'hF2, 1'b1);
    send_byte(8'hF3, 1'b1);
    @(posedge clock);
    #1 enable = 1'b0;
    repeat (10) @(posedge clock);
    #1 enable = 1'b1;
    send_word(32'h01020304);
    settle();
    chk("t5_strobes", 32'(nwr - base), 32'd1);
    chk("t5_addr", wa[base], 32'd0);
    chk("t5_data", wd[base], 32'h01020304);
    chk("t5_count", word_count, 32'd1);
    base = nwr;
    send_byte(8'hA1, 1'b1);
    send_byte(8'hA2, 1'b1);
    send_byte(8'hA3, 1'b1);
    bit_out(1'b0);
    bit_out(1'b1);
    bit_out(1'b0);
    @(posedge clock);
    #1 reset = 1'b1;
    @(negedge clock);
    chk("t6_write_in_reset", 32'(imem.write), 32'd0);
    @(posedge clock);
    #1 reset = 1'b0;
    rx = 1'b1;
    @(negedge clock);
    chk("t6_addr", imem.address, 32'd0);
    chk("t6_data", imem.data, 32'd0);
    chk("t6_count", word_count, 32'd0);
    chk("t6_done", 32'(load_done), 32'd0);
    chk("t6_err", 32'(err_framing), 32'd0);
    chk("t6_state", 32'(dut.u_rx.state_q), 32'(RX_IDLE));
    repeat (60) @(posedge clock);
    @(negedge clock);
    chk("t6_no_strobe", 32'(nwr - base), 32'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
